pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 6000, cycles locked must stay high before reset release (100 us at 60 MHz).
REQ-002 SHALL have parameter RST_STAGES, default 3, number of staggered reset outputs (1..8).
REQ-003 SHALL have parameter STAGE_GAP, default 16, cycles between successive stage releases (>=1).
REQ-004 SHALL have parameter LOSS_CNT_W, default 8, width of the loss-of-lock counter.
REQ-005 SHALL have port refclk, input, 1: single clock (60 MHz PLL outclk_0); all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port clr_status, input, 1: synchronous pulse that clears lock_lost and loss_count.
REQ-009 SHALL have port rst_out, output, RST_STAGES: active-high downstream resets; bit 0 releases first.
REQ-010 SHALL have port ready, output, 1: high when all stages are released and lock is held.
REQ-011 SHALL have port lock_lost, output, 1: sticky flag for any loss of lock after release began.
REQ-012 SHALL have port loss_count, output, LOSS_CNT_W: saturating count of loss-of-lock events.
REQ-013 SHALL have port state, output, 2: FSM state (0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN).

Function
REQ-014 SHALL pass locked through a 2-flop synchronizer; locked_s is the second flop, and no other logic samples locked directly.
REQ-015 WAIT_LOCK: rst_out all ones, ready 0, counters 0; locked_s=1 -> STABLE next edge.
REQ-016 STABLE: counter increments each cycle; locked_s=0 -> WAIT_LOCK with counter cleared and no loss event; counter==LOCK_STABLE_CYCLES-1 with locked_s=1 -> RELEASE, so STABLE lasts exactly LOCK_STABLE_CYCLES cycles.
REQ-017 RELEASE: gap counter runs 0..STAGE_GAP-1; at STAGE_GAP-1, rst_out[idx] clears, idx increments, gap counter wraps; rst_out[k] clears (k+1)*STAGE_GAP edges after RELEASE entry.
REQ-018 The edge that clears rst_out[RST_STAGES-1] SHALL also set ready=1 and move to RUN.
REQ-019 Released stages SHALL stay released; rst_out bits SHALL never release out of order.
REQ-020 RUN: holds; locked_s=0 -> WAIT_LOCK next edge.
REQ-021 A loss event is locked_s=0 in RELEASE or RUN; on the next edge: rst_out all ones, ready 0, state WAIT_LOCK, lock_lost 1, loss_count+1 saturating at all ones.
REQ-022 clr_status=1 SHALL clear lock_lost and loss_count next edge; on a simultaneous loss event, the loss wins (lock_lost=1, loss_count=1).
REQ-023 clr_status SHALL NOT affect state, rst_out or ready.
REQ-024 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-025 While rst=1, asynchronously and held: state WAIT_LOCK, rst_out all ones, ready 0, lock_lost 0, loss_count 0, synchronizer flops 0, counters 0.
REQ-026 rst asserted mid-RELEASE or RUN SHALL force the full reset values immediately and SHALL NOT count a loss.
REQ-027 After rst deasserts, the first state change SHALL occur only on a refclk edge.

Verification (bench params LOCK_STABLE_CYCLES=8, RST_STAGES=3, STAGE_GAP=4)
REQ-028 Locked held high from first sampling edge E0 -> STABLE at E2, RELEASE at E10, rst_out 3'b110 at E14, 3'b100 at E18, 3'b000 and ready=1 at E22.
REQ-029 Locked drops for 1 cycle during STABLE (counter=5) -> return to WAIT_LOCK, loss_count stays 0, full 8-cycle stability wait restarts.
REQ-030 Locked drops in RUN -> two sync edges later, rst_out=3'b111, ready=0, lock_lost=1, loss_count=1; relock repeats the REQ-028 sequence.
REQ-031 With LOSS_CNT_W=2, 5 loss events -> loss_count saturates at 3; clr_status pulse -> 0 and lock_lost=0.
REQ-032 clr_status on the same edge as a loss -> lock_lost=1, loss_count=1; rst pulse mid-RELEASE -> immediate reset values with loss_count unchanged at 0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Waits for a stable PLL lock, then releases a chain of downstream resets one
// stage at a time; any later loss of lock re-asserts every stage and is logged.
module pll_lock_supervisor #(
    parameter int LOCK_STABLE_CYCLES = 6000,
    parameter int RST_STAGES         = 3,
    parameter int STAGE_GAP          = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  clr_status,
    output logic [RST_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [1:0]            state
);
    localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GAP_W = $clog2(STAGE_GAP + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(STAGE_GAP - 1);
    localparam logic [RST_STAGES-1:0] LAST_STAGE = RST_STAGES'(1) << (RST_STAGES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  locked_s_q, locked_s_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [RST_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;
    logic                  loss_event;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            sync1_q      <= 1'b0;
            locked_s_q   <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
            rst_out_q    <= '1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            locked_s_q   <= locked_s_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync1_d      = locked;
        locked_s_d   = sync1_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        rst_out_d    = rst_out_q;
        ready_d      = ready_q;
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
        loss_event   = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d     = '0;
                gap_d     = '0;
                rst_out_d = '1;
                ready_d   = 1'b0;
                if (locked_s_q) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    gap_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                // Shifting in zeros from the bottom keeps releases strictly in order
                if (!locked_s_q) begin
                    loss_event = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    gap_d     = '0;
                    rst_out_d = rst_out_q << 1;
                    if (rst_out_q == LAST_STAGE) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            RUN: begin
                if (!locked_s_q) loss_event = 1'b1;
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (clr_status) begin
            lock_lost_d  = 1'b0;
            loss_count_d = '0;
        end

        // A loss on the same edge as a clear counts on top of the cleared value
        if (loss_event) begin
            state_d     = WAIT_LOCK;
            rst_out_d   = '1;
            ready_d     = 1'b0;
            cnt_d       = '0;
            gap_d       = '0;
            lock_lost_d = 1'b1;
            if (loss_count_d != '1) loss_count_d = loss_count_d + LOSS_CNT_W'(1);
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: milestone table for the lock
// sequence, hand-written corner sequences, and random stimulus against a model.
module tb_pll_lock_supervisor;
    localparam int LSC   = 8;
    localparam int NST   = 3;
    localparam int GAP   = 4;
    localparam int LW    = 2;
    localparam int T_RUN = LSC + NST * GAP;
    localparam int CMAX  = (1 << LW) - 1;
    localparam int ALL1  = (1 << NST) - 1;

    logic           refclk = 1'b0;
    logic           rst;
    logic           locked;
    logic           clr_status;
    logic [NST-1:0] rst_out;
    logic           ready;
    logic           lock_lost;
    logic [LW-1:0]  loss_count;
    logic [1:0]     state;

    int checks = 0;
    int errors = 0;

    // Model: locked seen two edges late; m_t = edges since the stability wait began
    logic lq[$];
    bit   m_seq;
    int   m_t;
    bit   m_lost;
    int   m_count;

    typedef struct {
        int edge_n;
        int st;
        int ro;
        int rdy;
    } mile_t;
    mile_t miles[11];

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES(LSC),
        .RST_STAGES        (NST),
        .STAGE_GAP         (GAP),
        .LOSS_CNT_W        (LW)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .clr_status(clr_status),
        .rst_out   (rst_out),
        .ready     (ready),
        .lock_lost (lock_lost),
        .loss_count(loss_count),
        .state     (state)
    );

    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        lq      = '{1'b0, 1'b0};
        m_seq   = 1'b0;
        m_t     = 0;
        m_lost  = 1'b0;
        m_count = 0;
    endtask

    task automatic modelStep(input logic lk, input logic clr);
        logic ls;
        bit   loss;
        ls   = lq.pop_front();
        lq.push_back(lk);
        loss = 1'b0;
        if (!m_seq) begin
            if (ls) begin
                m_seq = 1'b1;
                m_t   = 0;
            end
        end else if (!ls) begin
            if (m_t >= LSC) loss = 1'b1;
            m_seq = 1'b0;
            m_t   = 0;
        end else if (m_t < T_RUN) begin
            m_t++;
        end
        if (clr) begin
            m_lost  = 1'b0;
            m_count = 0;
        end
        if (loss) begin
            m_lost = 1'b1;
            if (m_count < CMAX) m_count++;
        end
    endtask

    function automatic int expState();
        if (!m_seq) return 0;
        if (m_t < LSC) return 1;
        if (m_t < T_RUN) return 2;
        return 3;
    endfunction

    function automatic int expRst();
        int rel;
        if (!m_seq || m_t < LSC) return ALL1;
        rel = (m_t - LSC) / GAP;
        if (rel > NST) rel = NST;
        return ALL1 & ~((1 << rel) - 1);
    endfunction

    function automatic int expReady();
        return (m_seq && m_t >= T_RUN) ? 1 : 0;
    endfunction

    task automatic compareModel();
        checkOutput("state", int'(state), expState());
        checkOutput("rst_out", int'(rst_out), expRst());
        checkOutput("ready", int'(ready), expReady());
        checkOutput("lock_lost", int'(lock_lost), int'(m_lost));
        checkOutput("loss_count", int'(loss_count), m_count);
    endtask

    // One refclk edge with the given inputs, then model update and full compare
    task automatic applyStimulus(input logic lk, input logic clr);
        locked     = lk;
        clr_status = clr;
        @(posedge refclk);
        modelStep(lk, clr);
        #1;
        compareModel();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, int'(state), 0);
        checkOutput({tag, "_rst_out"}, int'(rst_out), ALL1);
        checkOutput({tag, "_ready"}, int'(ready), 0);
        checkOutput({tag, "_lock_lost"}, int'(lock_lost), 0);
        checkOutput({tag, "_loss_count"}, int'(loss_count), 0);
    endtask

    // Asserts rst between edges, checks the immediate effect, holds it over an edge
    task automatic doReset(input string tag);
        rst        = 1'b1;
        locked     = 1'b0;
        clr_status = 1'b0;
        #1;
        checkResetValues({tag, "_async"});
        modelReset();
        @(posedge refclk);
        #1;
        checkResetValues({tag, "_held"});
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic cur;

        miles[0]  = '{1, 0, 7, 0};
        miles[1]  = '{2, 1, 7, 0};
        miles[2]  = '{9, 1, 7, 0};
        miles[3]  = '{10, 2, 7, 0};
        miles[4]  = '{13, 2, 7, 0};
        miles[5]  = '{14, 2, 6, 0};
        miles[6]  = '{17, 2, 6, 0};
        miles[7]  = '{18, 2, 4, 0};
        miles[8]  = '{21, 2, 4, 0};
        miles[9]  = '{22, 3, 0, 1};
        miles[10] = '{25, 3, 0, 1};

        rst        = 1'b1;
        locked     = 1'b0;
        clr_status = 1'b0;
        modelReset();
        @(posedge refclk);
        #1;
        checkResetValues("por");
        @(posedge refclk);
        #2;
        rst = 1'b0;

        // Lock sequence: locked high from E0, checked at fixed edges
        for (int e = 0; e <= 25; e++) begin
            applyStimulus(1'b1, 1'b0);
            for (int m = 0; m < 11; m++) begin
                if (miles[m].edge_n == e) begin
                    checkOutput($sformatf("seq_E%0d_state", e), int'(state), miles[m].st);
                    checkOutput($sformatf("seq_E%0d_rst_out", e), int'(rst_out), miles[m].ro);
                    checkOutput($sformatf("seq_E%0d_ready", e), int'(ready), miles[m].rdy);
                end
            end
        end

        // Loss in RUN: effect appears after the synchronizer delay
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("run_loss_early_state", int'(state), 3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("run_loss_state", int'(state), 0);
        checkOutput("run_loss_rst_out", int'(rst_out), 7);
        checkOutput("run_loss_ready", int'(ready), 0);
        checkOutput("run_loss_lost", int'(lock_lost), 1);
        checkOutput("run_loss_count", int'(loss_count), 1);
        for (int e = 0; e <= 22; e++) begin
            applyStimulus(1'b1, 1'b0);
            if (e == 21) checkOutput("relock_E21_state", int'(state), 2);
            if (e == 22) begin
                checkOutput("relock_E22_state", int'(state), 3);
                checkOutput("relock_E22_rst_out", int'(rst_out), 0);
            end
        end

        // Glitch during the stability wait restarts it without counting a loss
        doReset("rst1");
        for (int e = 0; e <= 17; e++) begin
            applyStimulus((e != 6), 1'b0);
            if (e == 7) checkOutput("glitch_E7_state", int'(state), 1);
            if (e == 8) begin
                checkOutput("glitch_E8_state", int'(state), 0);
                checkOutput("glitch_E8_count", int'(loss_count), 0);
                checkOutput("glitch_E8_lost", int'(lock_lost), 0);
            end
            if (e == 16) checkOutput("glitch_E16_state", int'(state), 1);
            if (e == 17) checkOutput("glitch_E17_state", int'(state), 2);
        end

        // Five losses saturate a 2-bit counter; a clear pulse empties it
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("sat_count", int'(loss_count), 3);
        checkOutput("sat_lost", int'(lock_lost), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("clr_count", int'(loss_count), 0);
        checkOutput("clr_lost", int'(lock_lost), 0);

        // Clear coinciding with a loss: the loss is counted from zero
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("pre_simul_count", int'(loss_count), 2);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("simul_state", int'(state), 0);
        checkOutput("simul_lost", int'(lock_lost), 1);
        checkOutput("simul_count", int'(loss_count), 1);

        // Reset mid-RELEASE returns everything to reset values at once
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_rst_state", int'(state), 2);
        doReset("rst2");

        // Randomized run against the model
        cur = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 23) == 0) cur = ~cur;
            applyStimulus(cur, ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
